ifid_instr_buf: RTL and testbench
=================================

Name: ifid_instr_buf

Overview:
- Instruction buffer between instruction-memory fetch and decode.
- Queues fetched instruction/PC pairs in a small FIFO with valid/ready handshakes on both sides.
- Flushes on trap/branch redirect.
- Splits the head instruction into the raw immediate fields and the 3-bit immediate-type selector consumed by the immediate generator.

Parameters:
- DEPTH, 2, FIFO entries; power of two, 2..8.
- RESET_PC_VAL, 32'h0000_0000, dec_pc value driven while empty.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  redirect/trap flush; empties buffer next edge.
- fetch_valid  in  1  fetch side has instruction.
- fetch_ready  out  1  buffer accepts (not full).
- fetch_pc  in  32  PC of fetched instruction.
- fetch_instr  in  32  fetched instruction word.
- dec_valid  out  1  head entry valid.
- dec_ready  in  1  decode consumes head.
- dec_pc  out  32  head PC.
- dec_instr  out  32  head instruction.
- imm_itype  out  12  instr[31:20].
- imm_stype  out  12  {instr[31:25],instr[11:7]}.
- imm_btype  out  12  {instr[31],instr[7],instr[30:25],instr[11:8]}.
- imm_utype  out  20  instr[31:12].
- imm_jtype  out  20  {instr[31],instr[19:12],instr[20],instr[30:21]}.
- shamt  out  5  instr[24:20].
- rs1  out  5  instr[19:15].
- typ  out  3  immediate selector (below).

Behaviour:
- Reset (async, rst_n=0): count=0, wr/rd pointers=0, all entries cleared to PC=0, instr=32'h0000_0013 (NOP). Outputs: dec_valid=0, fetch_ready=1, dec_pc=RESET_PC_VAL, dec_instr=32'h0000_0013, typ=3'b001, all immediate fields 0.
- Push when fetch_valid && fetch_ready && !flush. Pop when dec_valid && dec_ready && !flush.
- fetch_ready = (count != DEPTH); combinational from state only, never from dec_ready. Full buffer with a simultaneous pop still refuses a push that cycle.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Latency: instruction accepted at edge N is visible on dec_* after edge N; minimum 1 cycle, no combinational fetch-to-decode path.
- dec_valid = (count != 0). While empty, dec_pc/dec_instr show the reset values; fields and typ derive from dec_instr.
- Pointers wrap modulo DEPTH. count is DEPTH-aware: $clog2(DEPTH)+1 bits.
- Flush has priority over push and pop: count and pointers go to 0 next edge, and the push offered that cycle is dropped. Entries need not be cleared, but outputs must show NOP/RESET_PC_VAL while empty.
- Reset asserted mid-transfer discards all entries immediately.
- typ decode from dec_instr opcode [6:0] and funct3:
  - 0010011 (OP-IMM) with funct3 001/101 -> 110.
  - Other OP-IMM, 0000011 (LOAD), 1100111 (JALR) -> 001.
  - 0100011 (STORE) -> 010.
  - 1100011 (BRANCH) -> 011.
  - 0110111 (LUI), 0010111 (AUIPC) -> 100.
  - 1101111 (JAL) -> 101.
  - 1110011 (SYSTEM) with funct3[2]=1 -> 111; funct3 001/010/011 -> 001; funct3 000 -> 000.
  - All others (incl. 0110011) -> 000.

Optional Feature:
- IFID_ILLEGAL_CHECK_EN
  - Defined: adds output dec_illegal (1 bit). It is 1 when dec_valid and (instr[1:0]!=2'b11, or opcode not in the RV32I set above plus 0110011/0001111). Reset value 0; 0 when empty.
  - Undefined: port absent, no check logic.

Decomposition:
- Shared package ifid_pkg:
  - Opcode localparams: OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM, OPC_FENCE.
  - typ constants: IMM_NONE=000, IMM_I=001, IMM_S=010, IMM_B=011, IMM_U=100, IMM_J=101, IMM_SHAMT=110, IMM_ZIMM=111.
  - NOP constant 32'h0000_0013.
- One combinational sub-module, instr_field_split: dec_instr -> immediate fields, shamt, rs1, typ (and dec_illegal when enabled).
- FIFO storage and control stay in the top module.

Test Plan:
- Reset, then push 0x00500093 (addi x1,x0,5) at PC 0x0 -> next cycle dec_valid=1, dec_pc=0x0, typ=001, imm_itype=0x005, rs1=0.
- With dec_ready=0, push 0xFE000EE3 (beq) then 0x123452B7 (lui) -> fetch_ready=0 after 2 pushes. Third push held off. Head typ=011, imm_btype=0xFFE. After pop, typ=100, imm_utype=0x12345.
- Continuous push and pop every cycle for 10 instructions -> count stays 1, order preserved, no drops or duplicates.
- Full buffer plus flush=1 with fetch_valid=1 -> next cycle dec_valid=0, fetch_ready=1, dec_instr=0x00000013, and the pushed word is absent.
- Push 0x40305013 (srai) -> typ=110, shamt=3. Push 0x3402D073 (csrrwi zimm=5) -> typ=111, rs1=5. Push 0x00000073 (ecall) -> typ=000.
- rst_n pulled low mid-stream (asynchronously, between edges) -> dec_valid drops immediately; with IFID_ILLEGAL_CHECK_EN, pushing 0xFFFFFFFF -> dec_illegal=1.

Source files
------------

// File: rtl/ifid_pkg.sv
// ifid_pkg: opcodes, immediate-type selector codes and FIFO entry type shared by the IF/ID buffer
package ifid_pkg;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] IMM_NONE  = 3'b000;
    localparam logic [2:0] IMM_I     = 3'b001;
    localparam logic [2:0] IMM_S     = 3'b010;
    localparam logic [2:0] IMM_B     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_J     = 3'b101;
    localparam logic [2:0] IMM_SHAMT = 3'b110;
    localparam logic [2:0] IMM_ZIMM  = 3'b111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_entry_t;
endpackage

// File: rtl/ifid_instr_buf_if.sv
// ifid_instr_buf_if: fetch-side and decode-side valid/ready handshakes of the IF/ID buffer
interface ifid_instr_buf_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    modport master (
        output fetch_valid, fetch_pc, fetch_instr, dec_ready,
        input  fetch_ready, dec_valid, dec_pc, dec_instr
    );
    modport slave (
        input  fetch_valid, fetch_pc, fetch_instr, dec_ready,
        output fetch_ready, dec_valid, dec_pc, dec_instr
    );
endinterface

// File: rtl/instr_field_split.sv
// instr_field_split: raw immediate fields and immediate-type selector of the decode-head instruction
// IFID_ILLEGAL_CHECK_EN adds the illegal-opcode flag
module instr_field_split
    import ifid_pkg::*;
(
`ifdef IFID_ILLEGAL_CHECK_EN
    input  logic        valid,
    output logic        illegal,
`endif
    input  logic [31:0] instr,
    output logic [11:0] imm_itype,
    output logic [11:0] imm_stype,
    output logic [11:0] imm_btype,
    output logic [19:0] imm_utype,
    output logic [19:0] imm_jtype,
    output logic [4:0]  shamt,
    output logic [4:0]  rs1,
    output logic [2:0]  typ
);
    logic [6:0] opc;
    logic [2:0] f3;

    assign opc       = instr[6:0];
    assign f3        = instr[14:12];
    assign imm_itype = instr[31:20];
    assign imm_stype = {instr[31:25], instr[11:7]};
    assign imm_btype = {instr[31], instr[7], instr[30:25], instr[11:8]};
    assign imm_utype = instr[31:12];
    assign imm_jtype = {instr[31], instr[19:12], instr[20], instr[30:21]};
    assign shamt     = instr[24:20];
    assign rs1       = instr[19:15];

    always_comb begin
        typ = IMM_NONE;
        case (opc)
            OPC_OPIMM:          typ = (f3[1:0] == 2'b01) ? IMM_SHAMT : IMM_I;
            OPC_LOAD, OPC_JALR: typ = IMM_I;
            OPC_STORE:          typ = IMM_S;
            OPC_BRANCH:         typ = IMM_B;
            OPC_LUI, OPC_AUIPC: typ = IMM_U;
            OPC_JAL:            typ = IMM_J;
            OPC_SYSTEM:         typ = f3[2] ? IMM_ZIMM : (f3 != 3'b000) ? IMM_I : IMM_NONE;
            default:            typ = IMM_NONE;
        endcase
    end

`ifdef IFID_ILLEGAL_CHECK_EN
    logic known;

    always_comb begin
        known = 1'b0;
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP, OPC_LUI,
            OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM, OPC_FENCE: known = 1'b1;
            default: known = 1'b0;
        endcase
    end

    assign illegal = valid && (instr[1:0] != 2'b11 || !known);
`endif
endmodule

// File: rtl/ifid_instr_buf.sv
// ifid_instr_buf: fetch-to-decode instruction FIFO with flush and head-instruction field split
// IFID_ILLEGAL_CHECK_EN adds the dec_illegal output
module ifid_instr_buf
    import ifid_pkg::*;
#(
    parameter int          DEPTH        = 2,
    parameter logic [31:0] RESET_PC_VAL = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    ifid_instr_buf_if.slave bus,
    output logic [11:0]     imm_itype,
    output logic [11:0]     imm_stype,
    output logic [11:0]     imm_btype,
    output logic [19:0]     imm_utype,
    output logic [19:0]     imm_jtype,
    output logic [4:0]      shamt,
    output logic [4:0]      rs1,
    output logic [2:0]      typ
`ifdef IFID_ILLEGAL_CHECK_EN
    ,
    output logic            dec_illegal
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ifid_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    // ready depends on occupancy only, so a full buffer refuses even when decode pops
    assign bus.fetch_ready = count != CW'(DEPTH);
    assign bus.dec_valid   = count != '0;
    assign push            = bus.fetch_valid && bus.fetch_ready && !flush;
    assign pop             = bus.dec_valid && bus.dec_ready && !flush;
    assign bus.dec_pc      = bus.dec_valid ? mem[rd_ptr].pc : RESET_PC_VAL;
    assign bus.dec_instr   = bus.dec_valid ? mem[rd_ptr].instr : NOP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '{pc: 32'h0, instr: NOP};
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: bus.fetch_pc, instr: bus.fetch_instr};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    instr_field_split u_split (
`ifdef IFID_ILLEGAL_CHECK_EN
        .valid     (bus.dec_valid),
        .illegal   (dec_illegal),
`endif
        .instr     (bus.dec_instr),
        .imm_itype (imm_itype),
        .imm_stype (imm_stype),
        .imm_btype (imm_btype),
        .imm_utype (imm_utype),
        .imm_jtype (imm_jtype),
        .shamt     (shamt),
        .rs1       (rs1),
        .typ       (typ)
    );
endmodule

// File: tb/tb_ifid_instr_buf.sv
// tb_ifid_instr_buf: scoreboard bench for the IF/ID instruction buffer
// IFID_ILLEGAL_CHECK_EN enables the dec_illegal checks
module tb_ifid_instr_buf;
    import ifid_pkg::*;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic clk, rst_n, flush;
    logic [11:0] imm_itype, imm_stype, imm_btype;
    logic [19:0] imm_utype, imm_jtype;
    logic [4:0]  shamt, rs1;
    logic [2:0]  typ;
`ifdef IFID_ILLEGAL_CHECK_EN
    logic dec_illegal;
`endif
    int vectors = 0;
    int miscompares = 0;
    ifid_entry_t q[$];
    ifid_entry_t sb_e;

    ifid_instr_buf_if bus ();

    ifid_instr_buf #(.DEPTH(2), .RESET_PC_VAL(RPC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .imm_itype (imm_itype),
        .imm_stype (imm_stype),
        .imm_btype (imm_btype),
        .imm_utype (imm_utype),
        .imm_jtype (imm_jtype),
        .shamt     (shamt),
        .rs1       (rs1),
        .typ       (typ)
`ifdef IFID_ILLEGAL_CHECK_EN
        ,
        .dec_illegal (dec_illegal)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard: record accepted pushes, compare every decode-side pop in order
    always @(negedge clk) begin
        if (!rst_n || flush) q.delete();
        else begin
            if (bus.dec_valid && bus.dec_ready) begin
                chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    sb_e = q.pop_front();
                    chk("sb_pc", bus.dec_pc, sb_e.pc);
                    chk("sb_instr", bus.dec_instr, sb_e.instr);
                end
            end
            if (bus.fetch_valid && bus.fetch_ready) q.push_back('{pc: bus.fetch_pc, instr: bus.fetch_instr});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] ins);
        int n = 0;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        bus.fetch_instr = ins;
        @(negedge clk);
        while (!bus.fetch_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n == 20) chk("offer_timeout", 32'(bus.fetch_ready), 32'd1);
        step();
        bus.fetch_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.dec_ready = 1'b1;
        @(negedge clk);
        while (bus.dec_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("drain_empty", 32'(bus.dec_valid), 32'd0);
        step();
        bus.dec_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_instr = '0;
        bus.dec_ready   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
        chk("rst_dec_pc", bus.dec_pc, RPC);
        chk("rst_dec_instr", bus.dec_instr, NOP);
        chk("rst_typ", 32'(typ), 32'd1);
        chk("rst_imm", {imm_itype, imm_stype, imm_btype} | 32'(imm_utype) | 32'(imm_jtype) | 32'(shamt) | 32'(rs1), 32'd0);
`ifdef IFID_ILLEGAL_CHECK_EN
        chk("rst_illegal", 32'(dec_illegal), 32'd0);
`endif
        step();
        rst_n = 1'b1;

        offer(32'h0, 32'h0050_0093);
        @(negedge clk);
        chk("addi_valid", 32'(bus.dec_valid), 32'd1);
        chk("addi_pc", bus.dec_pc, 32'h0);
        chk("addi_typ", 32'(typ), 32'd1);
        chk("addi_itype", 32'(imm_itype), 32'h005);
        chk("addi_rs1", 32'(rs1), 32'd0);
`ifdef IFID_ILLEGAL_CHECK_EN
        chk("addi_illegal", 32'(dec_illegal), 32'd0);
`endif
        step();
        drain();

        offer(32'h4, 32'hFE00_0EE3);
        offer(32'h8, 32'h1234_52B7);
        @(negedge clk);
        chk("full_ready", 32'(bus.fetch_ready), 32'd0);
        chk("beq_typ", 32'(typ), 32'd3);
        chk("beq_btype", 32'(imm_btype), 32'hFFE);
        step();
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'hC;
        bus.fetch_instr = 32'h0000_0073;
        bus.dec_ready   = 1'b1;
        @(negedge clk);
        chk("full_pop_refuse", 32'(bus.fetch_ready), 32'd0);
        step();
        bus.dec_ready = 1'b0;
        @(negedge clk);
        chk("lui_typ", 32'(typ), 32'd4);
        chk("lui_utype", 32'(imm_utype), 32'h12345);
        step();
        bus.fetch_valid = 1'b0;
        drain();

        bus.dec_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.fetch_valid = 1'b1;
            bus.fetch_pc    = 32'h100 + 32'(i * 4);
            bus.fetch_instr = 32'h0000_0093 | (32'(i) << 20);
            @(negedge clk);
            chk("stream_ready", 32'(bus.fetch_ready), 32'd1);
            if (i > 0) chk("stream_valid", 32'(bus.dec_valid), 32'd1);
            step();
        end
        bus.fetch_valid = 1'b0;
        step();
        bus.dec_ready = 1'b0;
        @(negedge clk);
        chk("stream_drained", 32'(q.size()), 32'd0);
        chk("stream_empty", 32'(bus.dec_valid), 32'd0);
        step();

        offer(32'h300, 32'h0010_0093);
        offer(32'h304, 32'h0020_0093);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h308;
        bus.fetch_instr = 32'h0030_0093;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.fetch_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(bus.dec_valid), 32'd0);
        chk("flush_ready", 32'(bus.fetch_ready), 32'd1);
        chk("flush_instr", bus.dec_instr, NOP);
        chk("flush_pc", bus.dec_pc, RPC);
        step();
        @(negedge clk);
        chk("flush_dropped", 32'(bus.dec_valid), 32'd0);
        step();

        offer(32'h200, 32'h4030_5013);
        @(negedge clk);
        chk("srai_typ", 32'(typ), 32'd6);
        chk("srai_shamt", 32'(shamt), 32'd3);
        step();
        drain();
        offer(32'h204, 32'h3402_D073);
        @(negedge clk);
        chk("csrrwi_typ", 32'(typ), 32'd7);
        chk("csrrwi_rs1", 32'(rs1), 32'd5);
        step();
        drain();
        offer(32'h208, 32'h0000_0073);
        offer(32'h20C, 32'h0080_006F);
        @(negedge clk);
        chk("ecall_typ", 32'(typ), 32'd0);
        step();
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        @(negedge clk);
        chk("jal_typ", 32'(typ), 32'd5);
        chk("jal_jtype", 32'(imm_jtype), 32'h4);
        step();
        drain();
        offer(32'h210, 32'h0011_2423);
        @(negedge clk);
        chk("sw_typ", 32'(typ), 32'd2);
        chk("sw_stype", 32'(imm_stype), 32'h008);
        step();
        drain();

        offer(32'h400, 32'h0010_0093);
        offer(32'h404, 32'h0020_0093);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.dec_valid), 32'd0);
        chk("async_rst_ready", 32'(bus.fetch_ready), 32'd1);
        chk("async_rst_instr", bus.dec_instr, NOP);
        step();
        rst_n = 1'b1;
        step();

`ifdef IFID_ILLEGAL_CHECK_EN
        offer(32'h500, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("illegal_set", 32'(dec_illegal), 32'd1);
        step();
        drain();
        @(negedge clk);
        chk("illegal_empty", 32'(dec_illegal), 32'd0);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
